div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Iterative radix-2 restoring divider for DIV/DIVU in the EX stage; the source of the EX
//  stall request that the pipeline controller turns into stall=6'b001111.
//  EX holds start+operands while this block asserts stallreq (EX frozen by the stall vector);
//  on ready EX takes quotient->LO, remainder->HI, drops start and the pipeline resumes.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (>=4, power of 2)
// PORTS
//  clk         in   1      rising-edge clock
//  resetn      in   1      synchronous, active-high reset (1 = `RstEnable); one clock domain
//  start       in   1      divide request; held high by EX until the cycle after ready
//  annul       in   1      pipeline flush; cancels any operation in progress
//  signed_div  in   1      1 = DIV (two's complement), 0 = DIVU; sampled with start in IDLE
//  dividend    in   WIDTH  numerator; sampled in IDLE when start=1
//  divisor     in   WIDTH  denominator; sampled in IDLE when start=1
//  quotient    out  WIDTH  registered quotient (LO); valid while ready=1
//  remainder   out  WIDTH  registered remainder (HI); valid while ready=1
//  ready       out  1      result valid (registered)
//  stallreq    out  1      combinational: start & ~ready & ~annul & ~resetn; ORed into stallreq_from_ex
// BEHAVIOUR
//  Reset: state=IDLE, quotient=0, remainder=0, ready=0, counter=0; stallreq=0 during reset.
//  FSM (one transition per clk):
//   IDLE : start&~annul&divisor==0 -> END (quotient<=all-ones, remainder<=dividend, ready<=1)
//          start&~annul&divisor!=0 -> ON: latch |dividend|,|divisor| (abs only if signed_div),
//                                     sign flags, partial remainder=0, counter=0
//          else stay; ready=0.
//   ON   : one quotient bit per cycle, MSB first: shift {rem,q} left 1, trial = rem - divisor
//          (WIDTH+1-bit subtract); if non-negative keep trial and set q LSB=1, else restore.
//          counter++; after WIDTH iterations -> END and register results with ready<=1.
//          annul=1 or start=0 -> IDLE (abort), no result written.
//   END  : ready=1, results held stable; start=0 or annul=1 -> IDLE with ready<=0.
//          start still high -> stay in END (no restart until start low for >=1 cycle).
//  Sign fix-up (signed_div=1), applied when leaving ON: quotient negated if operand signs
//   differ; remainder takes sign of dividend. Divide-by-zero path applies no fix-up.
//  Overflow: signed 0x80000000 / -1 -> quotient 0x80000000, remainder 0 (falls out of the
//   unsigned abs path; no special casing, no exception).
//  Latency (start seen in IDLE at cycle 0): normal ready in cycle WIDTH+1 (33 for WIDTH=32),
//   stallreq high cycles 0..WIDTH; divisor 0: ready in cycle 1, stallreq high cycle 0 only.
//  annul has priority over start in every state; resetn has priority over everything.
//  Operand inputs are ignored outside IDLE (EX is frozen, but the block does not rely on it).
// TESTING
//  1 DIVU 100/7 -> cycle 33 ready=1, quotient=14, remainder=2; stallreq high exactly 33 cycles.
//  2 DIV 0xFFFFFFF9(-7)/2 -> quotient=0xFFFFFFFD(-3), remainder=0xFFFFFFFF(-1); DIV 7/-2 ->
//    q=0xFFFFFFFD, r=1.
//  3 DIVU 0x1234/0 -> cycle 1 ready=1, quotient=0xFFFFFFFF, remainder=0x1234; stallreq 1 cycle.
//  4 DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; DIVU 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//  5 annul=1 at cycle 10 of a divide -> IDLE next cycle, stallreq=0, ready never rises;
//    following DIVU 9/3 returns q=3 r=0 at full latency. Repeat with resetn=1 mid-ON -> all outputs 0.
//  6 hold start 5 cycles past ready -> ready/results stable, no restart; drop start 1 cycle,
//    re-raise with new operands -> fresh result after 33 cycles.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces one quotient bit per clock and raises stallreq until the result is ready.
`timescale 1ns/1ps
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             annul,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             stallreq
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_END  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quotient_d, remainder_d;
    logic             ready_d;

    logic             dividend_neg, divisor_neg;
    logic [WIDTH-1:0] dividend_abs, divisor_abs;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] rem_next, quo_next;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    assign stallreq = start & ~ready & ~annul & ~resetn;

    // Operand magnitudes and one restoring iteration on {rem, quo}.
    always_comb begin
        dividend_neg = signed_div & dividend[WIDTH-1];
        divisor_neg  = signed_div & divisor[WIDTH-1];
        dividend_abs = dividend_neg ? negate(dividend) : dividend;
        divisor_abs  = divisor_neg  ? negate(divisor)  : divisor;

        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvsr_q};
        if (trial[WIDTH]) begin
            rem_next = rem_sh[WIDTH-1:0];
            quo_next = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient;
        remainder_d = remainder;
        ready_d     = ready;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b0;
                if (start && !annul) begin
                    if (divisor == '0) begin
                        // Divide by zero: fixed result, no sign fix-up.
                        state_d     = S_END;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        ready_d     = 1'b1;
                    end else begin
                        state_d = S_ON;
                        rem_d   = '0;
                        quo_d   = dividend_abs;
                        dvsr_d  = divisor_abs;
                        q_neg_d = dividend_neg ^ divisor_neg;
                        r_neg_d = dividend_neg;
                        cnt_d   = '0;
                    end
                end
            end
            S_ON: begin
                if (annul || !start) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d     = S_END;
                        quotient_d  = q_neg_q ? negate(quo_next) : quo_next;
                        remainder_d = r_neg_q ? negate(rem_next) : rem_next;
                        ready_d     = 1'b1;
                    end
                end
            end
            S_END: begin
                // Hold the result until EX drops start; no restart while start stays high.
                if (annul || !start) begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            quotient  <= quotient_d;
            remainder <= remainder_d;
            ready     <= ready_d;
        end
    end

endmodule
